// File: rtl/vga_pkg.sv
// Shared types and widths for the VGA video RAM arbiter.
package vga_pkg;

  localparam int unsigned ADDR_W = 15;
  localparam int unsigned DATA_W = 16;

  typedef logic [DATA_W-1:0] color_t;
  typedef logic [ADDR_W-1:0] vaddr_t;

  typedef struct packed {
    vaddr_t addr;
    color_t data;
  } wr_entry_t;

endpackage

// File: rtl/vga_wr_fifo.sv
// Synchronous write-request FIFO. Holds CPU writes until the arbiter
// finds a free RAM slot. Caller must not push when full or pop when empty.
module vga_wr_fifo
  import vga_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push,
  input  wr_entry_t    push_data,
  input  logic         pop,
  output wr_entry_t    head,
  output logic [PTR_W:0] level,
  output logic         full,
  output logic         empty
);

  wr_entry_t          mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [PTR_W:0]     level_q;

  // Entry storage; contents are meaningless until written, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      level_q <= level_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    end
  end

  // Status and head-of-queue view.
  always_comb begin
    head  = mem_q[rd_ptr_q];
    level = level_q;
    full  = (level_q == (PTR_W+1)'(DEPTH));
    empty = (level_q == '0);
  end

endmodule

// File: rtl/vga_vram_arbiter.sv
// Shares a single-port video RAM between VGA pixel reads and queued CPU
// writes. The last word read is cached; cycles where the pixel address is
// unchanged are used to drain the write FIFO.
module vga_vram_arbiter #(
  parameter int unsigned ADDR_W     = vga_pkg::ADDR_W,
  parameter int unsigned DATA_W     = vga_pkg::DATA_W,
  parameter int unsigned FIFO_DEPTH = 4,
  localparam int unsigned LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic [DATA_W-1:0] vga_color,
  input  logic              wr_valid,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [LVL_W-1:0]  fifo_level
);

  import vga_pkg::*;

  logic [ADDR_W-1:0] tag_q;
  logic              tag_valid_q;
  logic              rd_pend_q;
  logic [DATA_W-1:0] cache_q;

  wr_entry_t fifo_head;
  wr_entry_t fifo_in;
  logic      fifo_full;
  logic      fifo_empty;
  logic      fifo_push;
  logic      read_slot;
  logic      write_slot;
  logic      wr_hit;

  // Wrap the CPU request as a queue entry; accept only when there is room.
  always_comb begin
    fifo_in   = '{addr: vaddr_t'(wr_addr), data: color_t'(wr_data)};
    fifo_push = wr_valid && !fifo_full;
    wr_ready  = !fifo_full;
  end

  vga_wr_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_wr_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (fifo_push),
    .push_data (fifo_in),
    .pop       (write_slot),
    .head      (fifo_head),
    .level     (fifo_level),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Slot decision: a new pixel address always wins; otherwise drain a write.
  always_comb begin
    read_slot  = !tag_valid_q || (vga_addr != tag_q);
    write_slot = !read_slot && !fifo_empty;
    wr_hit     = write_slot && (ADDR_W'(fifo_head.addr) == tag_q);
    ram_wdata  = DATA_W'(fifo_head.data);
    // Gate with reset so an in-flight write slot is aborted immediately.
    ram_we     = write_slot && reset_n;
    if (read_slot) begin
      ram_addr = vga_addr;
    end else if (write_slot) begin
      ram_addr = ADDR_W'(fifo_head.addr);
    end else begin
      ram_addr = tag_q;
    end
  end

  // Tag, pending-read flag and colour cache.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tag_q       <= '0;
      tag_valid_q <= 1'b0;
      rd_pend_q   <= 1'b0;
      cache_q     <= '0;
    end else begin
      if (read_slot) begin
        tag_q       <= vga_addr;
        tag_valid_q <= 1'b1;
        rd_pend_q   <= 1'b1;
      end else begin
        rd_pend_q   <= 1'b0;
      end
      // Write-through to the cached pixel beats a stale read return.
      if (wr_hit) begin
        cache_q <= DATA_W'(fifo_head.data);
      end else if (rd_pend_q) begin
        cache_q <= ram_rdata;
      end
    end
  end

  assign vga_color = cache_q;

endmodule

// File: doc/vga_vram_arbiter.md
# vga_vram_arbiter

- Shares one single-port synchronous video RAM between two clients:
  - the VGA controller, which reads pixel colours at the scaled screen address it generates;
  - a CPU-side write port.
- Sits directly upstream of the VGA controller: takes its 15-bit address output and returns the 16-bit colour word the controller consumes as its colour input.
- The controller's address advances at most once every 4 clocks. The arbiter caches the last word read and spends the repeated-address cycles draining a small CPU write FIFO into the RAM.

## Interface
Parameters:
- ADDR_W, 15, video RAM word address width
- DATA_W, 16, colour word width
- FIFO_DEPTH, 4, write FIFO entries (power of two, ≥2)

Ports:
- clk  in  1  system clock; all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- vga_addr  in  ADDR_W  pixel address from VGA controller
- vga_color  out  DATA_W  colour word to VGA controller
- wr_valid  in  1  CPU write request
- wr_addr  in  ADDR_W  CPU write address
- wr_data  in  DATA_W  CPU write data
- wr_ready  out  1  FIFO can accept; transfer when wr_valid && wr_ready
- ram_addr  out  ADDR_W  RAM address (combinational)
- ram_we  out  1  RAM write enable (combinational)
- ram_wdata  out  DATA_W  RAM write data
- ram_rdata  in  DATA_W  RAM read data, valid one clock after read issue
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

## Operation
State registers:
- tag (ADDR_W): last address read from RAM.
- tag_valid: tag holds a real address.
- rd_pend: a RAM read was issued last cycle.
- cache (DATA_W): last colour word; drives vga_color directly.
- FIFO: write queue.

Slot decision, combinational every cycle, two cases only:
- READ slot when !tag_valid || vga_addr != tag:
  - ram_addr=vga_addr, ram_we=0.
  - At the edge: tag<=vga_addr, tag_valid<=1, rd_pend<=1.
- WRITE slot otherwise, if FIFO non-empty:
  - ram_addr/ram_wdata = FIFO head, ram_we=1.
  - Pop at the edge; rd_pend<=0.
- Idle otherwise: ram_we=0, ram_addr=tag, rd_pend<=0.

Cache update:
- If rd_pend: cache<=ram_rdata.
- Write-through: in a WRITE slot with head address == tag, cache<=head data. This overrides a same-cycle rd_pend capture; the write data wins.

FIFO rules:
- wr_ready = (level < FIFO_DEPTH), independent of wr_valid.
- Push and pop in the same cycle leave level unchanged.
- Full: wr_ready=0. A held wr_valid is accepted on the cycle after a pop.
- Order is strictly FIFO.

Coherence and starvation limits:
- No forwarding from queued (not yet drained) FIFO entries. A read of such an address returns the old RAM content until the entry drains.
- Writes starve while vga_addr changes every cycle. This is legal; the FIFO simply holds.
- The controller's 4-clock address hold guarantees ≥3 write slots per pixel group.

Reset (reset_n low, asynchronous):
- tag_valid=0, rd_pend=0, cache=0 (so vga_color=0).
- FIFO emptied: fifo_level=0, wr_ready=1.
- ram_we forced 0 while reset_n is low.
- Reset mid-drain discards queued writes. A write slot in progress is aborted by the forced ram_we=0.

## Timing
- Read latency:
  - vga_addr new at edge N (READ slot during cycle N).
  - ram_rdata valid in cycle N+1.
  - vga_color valid after edge N+2: 2 clocks.
- Write-through to the cached address: vga_color shows the new data after the write slot's edge, 1 clock.
- Accepted write reaches RAM: at the earliest in the cycle after acceptance (entry at head, WRITE slot available).
- No combinational path from wr_valid to wr_ready.
- Combinational paths vga_addr→ram_addr and vga_addr→ram_we are intentional. The RAM registers its address.

## Structure
- Shared package vga_pkg:
  - ADDR_W/DATA_W constants;
  - typedef color_t (DATA_W);
  - typedef vaddr_t (ADDR_W);
  - typedef wr_entry_t struct {addr, data}.
- One sub-module vga_wr_fifo: synchronous FIFO of wr_entry_t with push/pop/level/full/empty and async active-low reset.
- Slot decision, tag and cache stay in vga_vram_arbiter.

## Test plan
- Reset mid-drain (level=3, reset_n low for 2 clocks) -> during and after reset: vga_color=0, fifo_level=0, wr_ready=1, ram_we=0; no RAM writes from the discarded entries.
- Static vga_addr=15'h03E8, RAM[0x03E8]=16'h1234 -> exactly one READ slot; vga_color=16'h1234 from edge 2 onward; no further reads.
- Push 5 writes back-to-back while vga_addr steps every 4 clocks:
  - wr_ready drops after the 4th push; the 5th is accepted after the first pop.
  - All 5 reach RAM in order; fifo_level returns to 0.
- Tag = 15'h0400, push {15'h0400, 16'hF800} with vga_addr held -> ram_we pulses once; vga_color=16'hF800 one clock after the write slot, with no read slot.
- vga_addr changes every clock with 2 writes queued -> ram_we stays 0 and fifo_level stays 2; once vga_addr holds, both drain within 3 clocks.
- Level 2, simultaneous push and pop -> fifo_level stays 2; popped entry written to RAM, pushed entry at tail.
